pio_in_edge_irq: RTL
====================

Name: pio_in_edge_irq

Overview:
- Parametrised Avalon-MM input PIO; successor to the fixed 4-bit read-only PIO in the video system.
- Adds:
  - multi-stage input synchroniser
  - per-bit edge capture with write-1-to-clear
  - interrupt mask and level IRQ to the interrupt controller
  - power-up edge blanking
- Sits between board-level inputs (buttons, switches, video status flags) and the system interconnect.

Parameters:
- WIDTH, 4: number of input bits, 1..32.
- EDGE_TYPE, 0: captured edge. 0 = rising, 1 = falling, 2 = any.
- SYNC_STAGES, 2: synchroniser flops per bit, 2..4.
- DEBOUNCE_CYCLES, 16: stability window in clocks. Used only with PIO_DEBOUNCE_EN; 2..65535.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  synchronous active-low reset.
- address  in  2  Avalon word address.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe.
- writedata  in  32  write data.
- in_port  in  WIDTH  asynchronous external inputs.
- readdata  out  32  registered read data.
- irq  out  1  level interrupt request.

Behaviour:
- Reset: one clock, synchronous active-low; all state is sampled on the rising edge of clk while reset_n = 0.
  - Cleared: synchroniser chain, edge history, edge_capture, irq_mask, blanking counter, readdata, irq.
  - All outputs read 0 during and after reset.
- Synchroniser: in_port passes through SYNC_STAGES flops per bit to give sync_in. Latency in_port -> sync_in is SYNC_STAGES cycles.
- Value stage: data_val = sync_in (see Optional Feature). prev_val is data_val registered by one cycle.
- Edge detection per bit:
  - rise = data_val & ~prev_val
  - fall = ~data_val & prev_val
  - EDGE_TYPE selects rise, fall or rise|fall.
- Blanking:
  - A counter loads SYNC_STAGES+1 at reset and decrements to 0.
  - Edge detection is suppressed while the counter is non-zero, so inputs already high at reset release do not report a false edge.
- Edge capture:
  - A detected edge sets its bit in edge_capture (sticky).
  - A write to address 3 (chipselect=1, write_n=0) clears every bit where writedata is 1.
  - Same-cycle edge and clear on one bit: the edge wins and the bit stays 1.
- Register map (word addresses):
  - 0 data: read = data_val zero-extended; writes ignored.
  - 1 reserved: reads 0; writes ignored.
  - 2 irq_mask: RW, WIDTH bits; upper writedata bits ignored; reads zero-extended.
  - 3 edge_capture: read = capture bits zero-extended; write-1-to-clear.
- Reads:
  - readdata is registered every clock from the current address, independent of chipselect.
  - Read latency is 1 clock; reads have no side effects.
- IRQ:
  - irq = OR of (edge_capture & irq_mask), registered, so it asserts 1 cycle after the capture bit sets.
  - irq stays high until the bit is cleared or masked off.
- End-to-end latency: edge on in_port -> capture bit set after SYNC_STAGES+1 clocks -> irq high one clock later.
- Widths: unused upper readdata bits are always 0. WIDTH=32 uses the full word.

Optional Feature:
- Macro: PIO_DEBOUNCE_EN.
- Defined:
  - Each bit has a counter of ceil(log2(DEBOUNCE_CYCLES+1)) bits.
  - While sync_in differs from data_val, the counter increments; when it reaches DEBOUNCE_CYCLES, data_val takes sync_in and the counter clears.
  - Any cycle with sync_in == data_val clears the counter.
  - Added latency is DEBOUNCE_CYCLES clocks.
  - Pulses shorter than DEBOUNCE_CYCLES are never seen in data or edge_capture.
- Undefined: data_val = sync_in; no counters are instantiated.

Test Plan:
- Reset/readback:
  - reset_n low 3 clocks with in_port=4'hF.
  - Expect all readdata at addresses 0-3 = 0 during reset; irq=0.
  - After release, address 0 reads 32'h0000000F and address 3 reads 0 (blanking suppressed the edge).
- Rising capture + IRQ:
  - EDGE_TYPE=0, write irq_mask=4'b0010, then drive in_port bit1 0->1.
  - Expect edge_capture=32'h2 at cycle SYNC_STAGES+1 and irq=1 one cycle later.
  - Write 32'h2 to address 3; irq drops the next cycle.
- Masking:
  - Edge on bit0 with mask=4'b0010.
  - Expect edge_capture=32'h1 and irq stays 0.
  - Write mask=4'b0011; irq goes 1 the next cycle.
- Clear/edge collision:
  - Write-1-to-clear on bit2 in the same cycle a new bit2 edge is detected.
  - Expect bit2 to remain 1.
- EDGE_TYPE=2:
  - Pulse bit3 high for 5 clocks.
  - Expect capture set after the rising edge; clear it; expect it set again after the falling edge.
- Debounce (PIO_DEBOUNCE_EN, DEBOUNCE_CYCLES=16):
  - A 10-cycle glitch on bit0 -> data and capture unchanged.
  - A 20-cycle high level -> data bit0=1 after SYNC_STAGES+16 clocks, and capture set.

Source files
------------

// File: rtl/pio_in_edge_irq_if.sv
// Avalon-MM slave bus for the edge-capturing input PIO.
// The master drives address/strobes/data; the slave returns registered readdata.
interface pio_in_edge_irq_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata
  );
endinterface

// File: rtl/pio_in_edge_irq.sv
// Avalon-MM input PIO: synchroniser, sticky edge capture (W1C), IRQ mask, power-up edge blanking.
// Optional per-bit input debounce when PIO_DEBOUNCE_EN is defined.
module pio_in_edge_irq #(
  parameter int unsigned WIDTH           = 4,
  parameter int unsigned EDGE_TYPE       = 0,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  pio_in_edge_irq_if.slave   bus,
  input  logic [WIDTH-1:0]   in_port,
  output logic               irq
);

  if (WIDTH < 1 || WIDTH > 32 || EDGE_TYPE > 2 || SYNC_STAGES < 2 || SYNC_STAGES > 4 ||
      DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > 65535) begin : g_param_check
    $error("pio_in_edge_irq: parameter out of range");
  end

  localparam int unsigned BlankW = $clog2(SYNC_STAGES + 2);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
  logic [WIDTH-1:0] sync_in, data_val, prev_q;
  logic [WIDTH-1:0] rise, fall, edge_det, clr;
  logic [WIDTH-1:0] capture_q, capture_d, mask_q, mask_d;
  logic [BlankW-1:0] blank_q;
  logic [31:0] rd_d, rd_q;
  logic        irq_q, wr;

  assign sync_in = sync_q[SYNC_STAGES-1];

`ifdef PIO_DEBOUNCE_EN
  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [WIDTH-1:0][CntW-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]           val_q, val_d;

  // data_val follows sync_in only after DEBOUNCE_CYCLES consecutive differing cycles.
  always_comb begin
    cnt_d = cnt_q;
    val_d = val_q;
    for (int i = 0; i < WIDTH; i++) begin
      if (sync_in[i] == val_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CntW'(DEBOUNCE_CYCLES - 1)) begin
        val_d[i] = sync_in[i];
        cnt_d[i] = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CntW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q <= '0;
      val_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      val_q <= val_d;
    end
  end

  assign data_val = val_q;
`else
  assign data_val = sync_in;
`endif

  assign wr = bus.chipselect && !bus.write_n;

  always_comb begin
    rise = data_val & ~prev_q;
    fall = ~data_val & prev_q;
    case (EDGE_TYPE)
      0:       edge_det = rise;
      1:       edge_det = fall;
      default: edge_det = rise | fall;
    endcase
    // Hide the reset-release step of inputs that were already asserted.
    if (blank_q != '0) edge_det = '0;

    clr    = (wr && bus.address == 2'd3) ? bus.writedata[WIDTH-1:0] : '0;
    // A new edge outranks a same-cycle clear.
    capture_d = (capture_q & ~clr) | edge_det;
    mask_d    = (wr && bus.address == 2'd2) ? bus.writedata[WIDTH-1:0] : mask_q;

    rd_d = '0;
    unique case (bus.address)
      2'd0:    rd_d[WIDTH-1:0] = data_val;
      2'd2:    rd_d[WIDTH-1:0] = mask_q;
      2'd3:    rd_d[WIDTH-1:0] = capture_q;
      default: rd_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync_q    <= '0;
      prev_q    <= '0;
      capture_q <= '0;
      mask_q    <= '0;
      blank_q   <= BlankW'(SYNC_STAGES + 1);
      rd_q      <= '0;
      irq_q     <= 1'b0;
    end else begin
      sync_q    <= {sync_q[SYNC_STAGES-2:0], in_port};
      prev_q    <= data_val;
      capture_q <= capture_d;
      mask_q    <= mask_d;
      if (blank_q != '0) blank_q <= blank_q - BlankW'(1);
      rd_q      <= rd_d;
      irq_q     <= |(capture_q & mask_q);
    end
  end

  assign bus.readdata = rd_q;
  assign irq          = irq_q;

endmodule
